// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: control inputs, LUT programming port, instruction memory and decoder-facing outputs.
// The slave modport is the fetch stage; the master modport is whoever drives it.
interface instr_fetch_if #(
  parameter int IW   = 9,
  parameter int PCW  = 10,
  parameter int LUTN = 16
);
  localparam int LW = $clog2(LUTN);

  logic           start;
  logic           stall;
  logic           branch_taken;
  logic [LW-1:0]  branch_idx;
  logic           lut_we;
  logic [LW-1:0]  lut_waddr;
  logic [PCW-1:0] lut_wdata;
  logic [IW-1:0]  imem_rdata;

  logic [PCW-1:0] imem_addr;
  logic [PCW-1:0] pc;
  logic [IW-1:0]  instr;
  logic [2:0]     opcode;
  logic           instr_valid;
  logic           done;
  logic           wrapped;
  logic [15:0]    cycles;

  modport master (
    output start, stall, branch_taken, branch_idx, lut_we, lut_waddr, lut_wdata, imem_rdata,
    input  imem_addr, pc, instr, opcode, instr_valid, done, wrapped, cycles
  );

  modport slave (
    input  start, stall, branch_taken, branch_idx, lut_we, lut_waddr, lut_wdata, imem_rdata,
    output imem_addr, pc, instr, opcode, instr_valid, done, wrapped, cycles
  );
endinterface

// File: rtl/instr_fetch.sv
// PC / fetch stage with IDLE-RUN-DONE sequencing, branch-target LUT and saturating run-cycle counter.
// Zero fetch latency (combinational imem); next PC takes effect at the following edge.
module instr_fetch #(
  parameter int             IW        = 9,
  parameter int             PCW       = 10,
  parameter int             LUTN      = 16,
  parameter logic [IW-1:0]  HALT_CODE = 9'h1FF
) (
  input  logic         clk,
  input  logic         reset,
  instr_fetch_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_n;
  logic [PCW-1:0] pc_q, pc_n;
  logic [15:0]    cyc_q, cyc_n;
  logic           wrap_q, wrap_n;
  logic [PCW-1:0] lut [LUTN];

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pc_q   <= '0;
      cyc_q  <= '0;
      wrap_q <= 1'b0;
      for (int i = 0; i < LUTN; i++) lut[i] <= '0;
    end else begin
      state  <= state_n;
      pc_q   <= pc_n;
      cyc_q  <= cyc_n;
      wrap_q <= wrap_n;
      // LUT is only programmable while idle so a running program sees stable targets
      if (state == IDLE && bus.lut_we) lut[bus.lut_waddr] <= bus.lut_wdata;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    cyc_n   = cyc_q;
    wrap_n  = wrap_q;
    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          state_n = RUN;
          pc_n    = '0;
          cyc_n   = '0;
          wrap_n  = 1'b0;
        end
      end
      RUN: begin
        cyc_n = (cyc_q == 16'hFFFF) ? cyc_q : cyc_q + 16'd1;
        // Stall outranks halt: a stalled halt fetch is retried, not executed
        if (!bus.stall) begin
          if (bus.imem_rdata == HALT_CODE) begin
            state_n = DONE;
          end else if (bus.branch_taken) begin
            pc_n = lut[bus.branch_idx];
          end else begin
            pc_n = pc_q + PCW'(1);
            if (&pc_q) wrap_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = bus.imem_rdata;
  assign bus.opcode      = bus.imem_rdata[IW-1:IW-3];
  assign bus.instr_valid = (state == RUN) && !bus.stall;
  assign bus.done        = (state == DONE);
  assign bus.wrapped     = wrap_q;
  assign bus.cycles      = cyc_q;
endmodule
